// File: rtl/slave_fifo.sv
// slave_fifo: bus-side target of the request protocol. Master writes are
// pushed into a small FIFO, master reads are served combinationally from the
// FIFO head and popped when the request ends. Status flags and an acknowledge
// pulse are exported to the local side.
//
// Handshake: a transfer is one contiguous run of req=1 cycles (at least one).
// rw and, for writes, data_bus are taken from the last req-high cycle. The
// transfer commits at the first rising clk edge that sees req=0 after that
// run. ack is high for exactly the one cycle that follows the commit edge.
// There is no backpressure: the slave always accepts, and records a dropped
// write or an empty read in the sticky overflow/underflow flags.
module slave_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     rw,
  inout  wire  [WIDTH-1:0]         data_bus,
  input  logic                     clr_err,
  output logic                     ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             req_q;
  logic             armed;
  logic             rw_q;
  logic [WIDTH-1:0] data_q;
  // req_q only means "req was low last cycle" once req has actually been
  // observed low since reset; otherwise a request already in flight when
  // reset is released would look like a fresh rising edge.
  logic             req_seen_low;

  logic rise;
  logic fall;
  logic commit;

  assign rise   = req && !req_q && req_seen_low;
  assign fall   = !req && req_q;
  assign commit = fall && armed;

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // Slave drives the bus only during a read request; an empty FIFO reads as 0.
  assign data_bus = (req && rw) ? (empty ? '0 : mem[rd_ptr]) : {WIDTH{1'bz}};

  // FIFO storage: written only on a committed, accepted write.
  always_ff @(posedge clk) begin
    if (commit && !rw_q && !full) begin
      mem[wr_ptr] <= data_q;
    end
  end

  // Request tracking, commit, pointers, occupancy and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q        <= 1'b0;
      req_seen_low <= 1'b0;
      armed        <= 1'b0;
      rw_q         <= 1'b0;
      data_q       <= '0;
      ack          <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      req_q <= req;
      ack   <= commit;

      if (!req) begin
        req_seen_low <= 1'b1;
      end

      // Keep the most recent in-request direction and bus word.
      if (req) begin
        rw_q   <= rw;
        data_q <= data_bus;
      end

      if (rise) begin
        armed <= 1'b1;
      end else if (commit) begin
        armed <= 1'b0;
      end

      // Clear first so that an error event in the same cycle wins.
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end

      if (commit) begin
        if (!rw_q) begin
          if (!full) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
          end else begin
            overflow <= 1'b1;
          end
        end else begin
          if (!empty) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            count  <= count - CNT_ONE;
          end else begin
            underflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_slave_fifo.sv
// tb_slave_fifo: directed bench for slave_fifo. A transfer-level queue model
// tracks the FIFO and flags; a per-cycle compare process checks every output
// against it, and the directed sequences pin literal values along the way.
module tb_slave_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             req;
  logic             rw;
  logic             clr_err;
  logic             ack;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
  wire  [WIDTH-1:0] data_bus;

  logic             tb_en;
  logic [WIDTH-1:0] tb_drive;

  assign data_bus = tb_en ? tb_drive : {WIDTH{1'bz}};

  slave_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .rw        (rw),
    .data_bus  (data_bus),
    .clr_err   (clr_err),
    .ack       (ack),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model / scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic             m_ovf;
  logic             m_unf;
  logic             m_ack;
  logic             check_en;
  int               n_checks;
  int               n_fail;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_ack = 1'b0;
  endtask

  // One committed transfer, as seen at its commit edge.
  task automatic model_commit(input logic is_read, input logic [WIDTH-1:0] wdata,
                              input logic clr);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (!is_read) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(wdata);
      else                      m_ovf = 1'b1;
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      else                  m_unf = 1'b1;
    end
    m_ack = 1'b1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("count", int'(count), exp_q.size());
      check("full", int'(full), int'(exp_q.size() == DEPTH));
      check("empty", int'(empty), int'(exp_q.size() == 0));
      check("overflow", int'(overflow), int'(m_ovf));
      check("underflow", int'(underflow), int'(m_unf));
      check("ack", int'(ack), int'(m_ack));
      if (req && rw) begin
        check("rd_bus", int'(data_bus), (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
      end else if (tb_en) begin
        check("bus_free", int'(data_bus), int'(tb_drive));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [WIDTH-1:0] v, input logic ce);
    req = 1'b1; rw = 1'b0; tb_en = 1'b1; tb_drive = v;
    @(posedge clk); #1;
    req = 1'b0; tb_en = 1'b0; clr_err = ce;
    @(posedge clk);
    model_commit(1'b0, v, ce);
    #1 clr_err = 1'b0;
    @(posedge clk);
    m_ack = 1'b0;
    #1;
  endtask

  task automatic do_read(input logic [WIDTH-1:0] lit);
    req = 1'b1; rw = 1'b1;
    @(negedge clk);
    check("read_literal", int'(data_bus), int'(lit));
    @(posedge clk); #1;
    req = 1'b0; rw = 1'b0;
    @(posedge clk);
    model_commit(1'b1, '0, 1'b0);
    #1;
    @(posedge clk);
    m_ack = 1'b0;
    #1;
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    @(posedge clk);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1 clr_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    check_en = 1'b0;
    rst = 1'b1; req = 1'b0; rw = 1'b0; clr_err = 1'b0;
    tb_en = 1'b0; tb_drive = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    // Reset state; slave must leave the bus to another driver.
    tb_en = 1'b1; tb_drive = 4'h9;
    #1;
    check("rst_empty", int'(empty), 1);
    check("rst_count", int'(count), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_bus_free", int'(data_bus), 9);
    tb_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_en = 1'b1;
    @(posedge clk); #1;

    // Basic write / read order.
    do_write(4'hA, 1'b0);
    check("cnt_after_w1", int'(count), 1);
    do_write(4'h5, 1'b0);
    check("cnt_after_w2", int'(count), 2);
    do_write(4'h3, 1'b0);
    check("cnt_after_w3", int'(count), 3);
    do_read(4'hA);
    do_read(4'h5);
    do_read(4'h3);
    check("empty_after_reads", int'(empty), 1);

    // Full, overflow, wrap.
    for (int i = 1; i <= 4; i++) do_write(WIDTH'(i), 1'b0);
    check("full_after_4", int'(full), 1);
    do_write(4'hF, 1'b0);
    check("ovf_set", int'(overflow), 1);
    check("cnt_stays_4", int'(count), 4);
    for (int i = 1; i <= 4; i++) do_read(WIDTH'(i));
    do_write(4'h7, 1'b0);
    do_read(4'h7);

    // Read while empty.
    do_read(4'h0);
    check("unf_set", int'(underflow), 1);
    check("cnt_stays_0", int'(count), 0);
    clear_errors();
    check("unf_cleared", int'(underflow), 0);
    check("ovf_cleared", int'(overflow), 0);

    // Overflow coinciding with clr_err: set wins.
    do_write(4'h8, 1'b0);
    do_write(4'h9, 1'b0);
    do_write(4'hB, 1'b0);
    do_write(4'hC, 1'b0);
    do_write(4'hD, 1'b1);
    check("ovf_set_wins", int'(overflow), 1);
    check("cnt_full", int'(count), 4);

    // Reset in the middle of a write with req high.
    req = 1'b1; rw = 1'b0; tb_en = 1'b1; tb_drive = 4'h6;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_count", int'(count), 0);
    check("midrst_empty", int'(empty), 1);
    check("midrst_full", int'(full), 0);
    check("midrst_ovf", int'(overflow), 0);
    check("midrst_ack", int'(ack), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    req = 1'b0; tb_en = 1'b0;
    @(posedge clk); #1;
    check("no_ack_after_rst", int'(ack), 0);
    check("no_commit_after_rst", int'(count), 0);
    @(posedge clk); #1;
    check("no_ack_later", int'(ack), 0);

    // Normal operation resumes.
    do_write(4'h2, 1'b0);
    check("cnt_resume", int'(count), 1);
    do_read(4'h2);

    @(posedge clk);
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_fifo.md
# slave_fifo

Bus-side target stage for the asynchronous request protocol: sits directly downstream of the protocol master on the shared `req`/`rw`/`data_bus` lines. Master writes (`rw`=0) push the 4-bit bus word into an internal FIFO. Master reads (`rw`=1) are served combinationally from the FIFO head while `req` is high, then popped. Status flags and an acknowledge pulse are exported to the local side.

## Interface
- `WIDTH`, 4: bus and FIFO word width.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  1  transfer request from the master; high for one or more cycles per transfer.
- `rw`  in  1  transfer direction from the master; 1 = read (slave drives), 0 = write (master drives).
- `data_bus`  inout  WIDTH  shared bidirectional data bus.
- `clr_err`  in  1  synchronous clear of the sticky error flags.
- `ack`  out  1  one-cycle pulse per committed transfer.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `full`  out  1  `count` == DEPTH.
- `empty`  out  1  `count` == 0.
- `overflow`  out  1  sticky: a write was dropped because the FIFO was full.
- `underflow`  out  1  sticky: a read was served with the FIFO empty.

## Operation
- Reset values:
  - `ack`=0, `count`=0, `full`=0, `empty`=1, `overflow`=0, `underflow`=0.
  - Pointers, `req_q`, `armed`, `rw_q` and `data_q` are 0.
  - FIFO contents are don't-care.
- Bus drive is combinational:
  - `req`&&`rw` && !`empty`: `data_bus` = FIFO head.
  - `req`&&`rw` && `empty`: `data_bus` = 0.
  - Otherwise `data_bus` = high-Z.
  - The slave never drives while `rw`=0.
- Edge detection uses a registered `req_q` (previous-cycle `req`):
  - Rise (`req`=1, `req_q`=0) sets `armed`.
  - While `req`=1, `rw_q` <= `rw` and `data_q` <= `data_bus` every cycle, so the last in-request values are held.
- Commit happens at the clock edge where fall is seen (`req`=0, `req_q`=1) and `armed`=1:
  - Clear `armed`.
  - Assert `ack` for the next cycle.
  - `rw_q`=0 and not `full`: write `data_q` at the write pointer; increment the write pointer (mod DEPTH) and `count`.
  - `rw_q`=0 and `full`: data dropped; set `overflow`; pointers and `count` unchanged.
  - `rw_q`=1 and not `empty`: increment the read pointer (mod DEPTH); decrement `count`.
  - `rw_q`=1 and `empty`: set `underflow`; pointers unchanged.
- A fall with `armed`=0 (e.g. `req` already high when reset released) is ignored: no `ack`, no state change.
- Pointers are log2(DEPTH) bits and wrap naturally. `full` and `empty` are decoded from `count`.
- `clr_err`=1 clears `overflow` and `underflow` next edge. If an error event coincides with `clr_err`, the flag ends up set (set wins).
- Reset asserted mid-transfer returns all state to reset values immediately. No commit occurs for the interrupted transfer.

## Timing
- Read data is valid on `data_bus` in the same cycle `req`&&`rw` rises (zero latency). It stays stable until `req` falls, because the head only changes at commit.
- Commit edge: first rising `clk` edge with `req`=0 after ≥1 cycle of `req`=1.
- `count`, `full`, `empty`, `overflow` and `underflow` update at the commit edge.
- `ack` is high exactly one cycle, starting at the commit edge.
- Minimum `req`-high width: 1 cycle. Minimum `req`-low gap between transfers: 1 cycle. Back-to-back transfers commit every 2 cycles.
- `data_bus` sampled for a write is the value present in the final `req`-high cycle.

## Test plan
- After reset: `empty`=1, `count`=0, `ack`=0, `data_bus` high-Z.
- Master writes 4'hA, 4'h5, 4'h3:
  - `count` goes 1, 2, 3.
  - One `ack` pulse per transfer, each the cycle after `req` falls.
- Reads then return 4'hA, 4'h5, 4'h3 in order, each visible on `data_bus` while `req` is high. `empty`=1 after the third.
- Full/overflow/wrap:
  - Write 4'h1–4'h4 → `full`=1.
  - Fifth write of 4'hF → `overflow`=1, `count` stays 4.
  - Read all four → 1, 2, 3, 4.
  - Write 4'h7 and read it back → 4'h7, confirming pointer wrap.
- Read when empty:
  - `data_bus`=0 while `req` high, `underflow`=1, `ack` pulses, `count` stays 0.
  - `clr_err` clears `underflow`. An overflow event in the same cycle as `clr_err` leaves `overflow`=1.
- Reset mid-operation:
  - Assert `rst` during a write with `req` high → flags at reset values immediately.
  - Release `rst` with `req` still high, then drop `req` → no `ack`, `count` stays 0.
